// File: rtl/axi4_read_stream_master.sv
// rtl/axi4_read_stream_master.sv - AXI4 burst reader feeding an AXI4-Stream through a FWFT FIFO (optional: AXI4_RSTREAM_RRESP_CHECK_EN)
module axi4_read_stream_master #(
  parameter int AXI_ID_WIDTH   = 4,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_LEN_WIDTH  = 8,
  parameter int AXI_DATA_SIZE  = 2,
  parameter int AXI_DATA_WIDTH = (8 << AXI_DATA_SIZE),
  parameter int MAX_BURST      = 16,
  parameter int FIFO_PTR_WIDTH = 6,
  parameter int COUNT_WIDTH    = 24
) (
  input  logic                      aresetn,
  input  logic                      aclk,
  input  logic                      start,
  input  logic [AXI_ADDR_WIDTH-1:0] base_addr,
  input  logic [COUNT_WIDTH-1:0]    total_beats,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic [AXI_ID_WIDTH-1:0]   m_axi4_arid,
  output logic [AXI_ADDR_WIDTH-1:0] m_axi4_araddr,
  output logic [AXI_LEN_WIDTH-1:0]  m_axi4_arlen,
  output logic [2:0]                m_axi4_arsize,
  output logic [1:0]                m_axi4_arburst,
  output logic                      m_axi4_arlock,
  output logic [3:0]                m_axi4_arcache,
  output logic [2:0]                m_axi4_arprot,
  output logic [3:0]                m_axi4_arqos,
  output logic                      m_axi4_arvalid,
  input  logic                      m_axi4_arready,
  input  logic [AXI_ID_WIDTH-1:0]   m_axi4_rid,
  input  logic [AXI_DATA_WIDTH-1:0] m_axi4_rdata,
  input  logic [1:0]                m_axi4_rresp,
  input  logic                      m_axi4_rlast,
  input  logic                      m_axi4_rvalid,
  output logic                      m_axi4_rready,
  output logic [AXI_DATA_WIDTH-1:0] m_axis_tdata,
  output logic                      m_axis_tlast,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready
);

  localparam int DEPTH = 1 << FIFO_PTR_WIDTH;
  localparam int FW    = FIFO_PTR_WIDTH + 1;
  // Wide enough for fifo_count + reserved + a page-limited burst length
  localparam int SW    = FIFO_PTR_WIDTH + 16;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

  state_t                    state;
  logic [AXI_ADDR_WIDTH-1:0] addr;
  logic [COUNT_WIDTH-1:0]    remaining;
  logic [COUNT_WIDTH-1:0]    total;
  logic [COUNT_WIDTH-1:0]    out_count;
  logic [SW-1:0]             cur_len;
  logic [FW-1:0]             reserved;

  logic [AXI_DATA_WIDTH-1:0] mem [DEPTH];
  logic [FIFO_PTR_WIDTH-1:0] wr_ptr;
  logic [FIFO_PTR_WIDTH-1:0] rd_ptr;
  logic [FW-1:0]             fifo_count;

  logic [12:0]               page_beats;
  logic [SW-1:0]             rem_cap;
  logic [SW-1:0]             burst_len;
  logic                      space_ok;
  logic                      ar_fire;
  logic                      r_fire;
  logic                      t_fire;

  assign m_axi4_arid    = '0;
  assign m_axi4_arsize  = 3'(AXI_DATA_SIZE);
  assign m_axi4_arburst = 2'b01;
  assign m_axi4_arlock  = 1'b0;
  assign m_axi4_arcache = 4'b0011;
  assign m_axi4_arprot  = 3'b000;
  assign m_axi4_arqos   = 4'b0000;

  // Space is reserved before each AR, so R beats can always be taken while busy
  assign m_axi4_rready = busy;

  assign ar_fire = m_axi4_arvalid && m_axi4_arready;
  assign r_fire  = m_axi4_rvalid && m_axi4_rready;
  assign t_fire  = m_axis_tvalid && m_axis_tready;

  assign m_axis_tvalid = (fifo_count != '0);
  assign m_axis_tdata  = mem[rd_ptr];
  assign m_axis_tlast  = m_axis_tvalid && (out_count == total - COUNT_WIDTH'(1));

  // Next burst length: limited by MAX_BURST, beats left, and the 4 KB page end
  always_comb begin
    page_beats = (13'h1000 - {1'b0, addr[11:0]}) >> AXI_DATA_SIZE;
    rem_cap    = (remaining > COUNT_WIDTH'(MAX_BURST)) ? SW'(MAX_BURST) : SW'(remaining);
    burst_len  = (rem_cap < SW'(page_beats)) ? rem_cap : SW'(page_beats);
    space_ok   = (SW'(fifo_count) + SW'(reserved) + burst_len) <= SW'(DEPTH);
  end

  // Command FSM: latches the command, issues AR bursts, waits for the final stream beat
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state          <= S_IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      addr           <= '0;
      remaining      <= '0;
      total          <= '0;
      out_count      <= '0;
      cur_len        <= '0;
      m_axi4_arvalid <= 1'b0;
      m_axi4_araddr  <= '0;
      m_axi4_arlen   <= '0;
    end else begin
      done <= 1'b0;
      if (t_fire) out_count <= out_count + COUNT_WIDTH'(1);
      case (state)
        S_IDLE: begin
          if (start) begin
            if (total_beats != '0) begin
              addr      <= base_addr & ~AXI_ADDR_WIDTH'((1 << AXI_DATA_SIZE) - 1);
              remaining <= total_beats;
              total     <= total_beats;
              out_count <= '0;
              busy      <= 1'b1;
              state     <= S_ISSUE;
            end else begin
              done <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          if (m_axi4_arvalid) begin
            if (m_axi4_arready) begin
              m_axi4_arvalid <= 1'b0;
              addr           <= addr + (AXI_ADDR_WIDTH'(cur_len) << AXI_DATA_SIZE);
              remaining      <= remaining - COUNT_WIDTH'(cur_len);
              if (remaining == COUNT_WIDTH'(cur_len)) state <= S_DRAIN;
            end
          end else if (space_ok) begin
            m_axi4_arvalid <= 1'b1;
            m_axi4_araddr  <= addr;
            m_axi4_arlen   <= AXI_LEN_WIDTH'(burst_len - SW'(1));
            cur_len        <= burst_len;
          end
        end
        S_DRAIN: begin
          if (t_fire && m_axis_tlast) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Beats granted on AR but not yet landed in the FIFO
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      reserved <= '0;
    end else begin
      reserved <= reserved + (ar_fire ? FW'(cur_len) : FW'(0)) - (r_fire ? FW'(1) : FW'(0));
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (r_fire) wr_ptr <= wr_ptr + FIFO_PTR_WIDTH'(1);
      if (t_fire) rd_ptr <= rd_ptr + FIFO_PTR_WIDTH'(1);
      fifo_count <= fifo_count + (r_fire ? FW'(1) : FW'(0)) - (t_fire ? FW'(1) : FW'(0));
    end
  end

  // FIFO storage write; read side is fall-through from rd_ptr
  always_ff @(posedge aclk) begin
    if (r_fire) mem[wr_ptr] <= m_axi4_rdata;
  end

`ifdef AXI4_RSTREAM_RRESP_CHECK_EN
  // Sticky read-response error, cleared by a new command
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      err <= 1'b0;
    end else if (state == S_IDLE && start) begin
      err <= 1'b0;
    end else if (r_fire && m_axi4_rresp != 2'b00) begin
      err <= 1'b1;
    end
  end
  logic unused_inputs;
  assign unused_inputs = &{1'b0, m_axi4_rid, m_axi4_rlast};
`else
  assign err = 1'b0;
  logic unused_inputs;
  assign unused_inputs = &{1'b0, m_axi4_rid, m_axi4_rlast, m_axi4_rresp};
`endif

endmodule

// File: tb/tb_axi4_read_stream_master.sv
// tb/tb_axi4_read_stream_master.sv - directed self-checking bench for axi4_read_stream_master
module tb_axi4_read_stream_master;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        start = 1'b0;
  logic [31:0] base_addr = '0;
  logic [23:0] total_beats = '0;
  logic        busy, done, err;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic [3:0]  arqos;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;
  logic [31:0] tdata;
  logic        tlast, tvalid;
  logic        tready = 1'b1;
  logic        inject = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  axi4_read_stream_master dut (
    .aresetn(aresetn), .aclk(aclk), .start(start), .base_addr(base_addr),
    .total_beats(total_beats), .busy(busy), .done(done), .err(err),
    .m_axi4_arid(arid), .m_axi4_araddr(araddr), .m_axi4_arlen(arlen),
    .m_axi4_arsize(arsize), .m_axi4_arburst(arburst), .m_axi4_arlock(arlock),
    .m_axi4_arcache(arcache), .m_axi4_arprot(arprot), .m_axi4_arqos(arqos),
    .m_axi4_arvalid(arvalid), .m_axi4_arready(arready),
    .m_axi4_rid(4'd0), .m_axi4_rdata(rdata), .m_axi4_rresp(rresp),
    .m_axi4_rlast(rlast), .m_axi4_rvalid(rvalid), .m_axi4_rready(rready),
    .m_axis_tdata(tdata), .m_axis_tlast(tlast), .m_axis_tvalid(tvalid),
    .m_axis_tready(tready)
  );

  function automatic logic [31:0] tb_data(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  // Slave model: always ready on AR, serves logged bursts back-to-back on R
  logic [31:0] ar_addr [64];
  logic [7:0]  ar_len  [64];
  int ar_n, ar_beats, r_idx, r_beat, r_count;

  assign arready = 1'b1;
  assign rvalid  = (r_idx < ar_n);
  assign rdata   = tb_data(ar_addr[r_idx] + 32'(r_beat * 4));
  assign rlast   = (r_beat == int'(ar_len[r_idx]));
  assign rresp   = (inject && r_count == 2) ? 2'b10 : 2'b00;

  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ar_n <= 0; ar_beats <= 0; r_idx <= 0; r_beat <= 0; r_count <= 0;
    end else begin
      if (arvalid && arready) begin
        ar_addr[ar_n] <= araddr;
        ar_len[ar_n]  <= arlen;
        ar_n          <= ar_n + 1;
        ar_beats      <= ar_beats + int'(arlen) + 1;
      end
      if (rvalid && rready) begin
        r_count <= r_count + 1;
        if (rlast) begin
          r_idx <= r_idx + 1; r_beat <= 0;
        end else begin
          r_beat <= r_beat + 1;
        end
      end
    end
  end

  // Stream sink log
  logic [31:0] out_data [256];
  logic        out_last [256];
  int out_n, done_n, last_cyc, done_cyc;

  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      out_n <= 0; done_n <= 0; last_cyc <= -1; done_cyc <= -1;
    end else begin
      if (tvalid && tready) begin
        out_data[out_n] <= tdata;
        out_last[out_n] <= tlast;
        out_n <= out_n + 1;
        if (tlast) last_cyc <= cyc;
      end
      if (done) begin
        done_n <= done_n + 1; done_cyc <= cyc;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge aclk); aresetn = 1'b0;
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
  endtask

  task automatic cmd(input logic [31:0] b, input logic [23:0] n);
    @(negedge aclk); base_addr = b; total_beats = n; start = 1'b1;
    @(negedge aclk); start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int bound);
    int k = 0;
    while (done_n == 0 && k < bound) begin
      @(negedge aclk); k++;
    end
    check({tag, "_done_seen"}, 64'(done_n != 0), 64'd1);
  endtask

  task automatic check_stream(input string tag, input logic [31:0] b, input int n);
    int bad = 0;
    for (int i = 0; i < n; i++) begin
      if (out_data[i] !== tb_data(b + 32'(i * 4))) bad++;
      if (out_last[i] !== (i == n - 1)) bad++;
    end
    check({tag, "_beats"}, 64'(out_n), 64'(n));
    check({tag, "_data_last_bad"}, 64'(bad), 64'd0);
    check({tag, "_done_count"}, 64'(done_n), 64'd1);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge aclk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_arvalid", 64'(arvalid), 64'd0);
    check("rst_tvalid", 64'(tvalid), 64'd0);
    check("rst_tlast", 64'(tlast), 64'd0);
    aresetn = 1'b1;
    @(negedge aclk);

    // Single short command
    cmd(32'h100, 24'd4);
    check("t1_busy", 64'(busy), 64'd1);
    wait_done("t1", 200);
    check("t1_ar_n", 64'(ar_n), 64'd1);
    check("t1_ar0_addr", 64'(ar_addr[0]), 64'h100);
    check("t1_ar0_len", 64'(ar_len[0]), 64'd3);
    check("t1_ar_consts", {arid, arsize, arburst, arlock, arcache, arprot, arqos},
          {4'd0, 3'd2, 2'b01, 1'b0, 4'b0011, 3'b000, 4'd0});
    check_stream("t1", 32'h100, 4);
    check("t1_done_latency", 64'(done_cyc - last_cyc), 64'd1);
    @(negedge aclk);
    check("t1_idle_busy", 64'(busy), 64'd0);

    // Burst splitting, plus a start while busy that must be ignored
    do_reset();
    cmd(32'h0, 24'd40);
    repeat (3) @(negedge aclk);
    cmd(32'h5000, 24'd8);
    wait_done("t2", 400);
    repeat (10) @(negedge aclk);
    check("t2_ar_n", 64'(ar_n), 64'd3);
    check("t2_ar_addrs", {ar_addr[0], ar_addr[1]}, {32'h0, 32'h40});
    check("t2_ar2_addr", 64'(ar_addr[2]), 64'h80);
    check("t2_ar_lens", {ar_len[0], ar_len[1], ar_len[2]}, {8'd15, 8'd15, 8'd7});
    check_stream("t2", 32'h0, 40);

    // 4 KB boundary split
    do_reset();
    cmd(32'hFF8, 24'd8);
    wait_done("t3", 200);
    check("t3_ar_n", 64'(ar_n), 64'd2);
    check("t3_ar0", {ar_addr[0], ar_len[0]}, {32'hFF8, 8'd1});
    check("t3_ar1", {ar_addr[1], ar_len[1]}, {32'h1000, 8'd5});
    check_stream("t3", 32'hFF8, 8);

    // Zero-length command
    do_reset();
    cmd(32'h300, 24'd0);
    check("t4_busy", 64'(busy), 64'd0);
    wait_done("t4", 10);
    repeat (5) @(negedge aclk);
    check("t4_ar_n", 64'(ar_n), 64'd0);
    check("t4_done_count", 64'(done_n), 64'd1);

    // Backpressure: FIFO fills to depth 64, then AR issue stops
    do_reset();
    tready = 1'b0;
    cmd(32'h2000, 24'd200);
    repeat (150) @(negedge aclk);
    check("t5_ar_beats", 64'(ar_beats), 64'd64);
    check("t5_arvalid", 64'(arvalid), 64'd0);
    check("t5_r_count", 64'(r_count), 64'd64);
    check("t5_out_n", 64'(out_n), 64'd0);
    tready = 1'b1;
    wait_done("t5", 2000);
    check("t5_ar_beats_end", 64'(ar_beats), 64'd200);
    check_stream("t5", 32'h2000, 200);

    // Asynchronous reset mid-DRAIN, then a fresh command
    do_reset();
    tready = 1'b0;
    cmd(32'h400, 24'd4);
    repeat (20) @(negedge aclk);
    check("t6_pre_busy", 64'({busy, tvalid}), 64'b11);
    #2 aresetn = 1'b0;
    #1;
    check("t6_rst_busy", 64'(busy), 64'd0);
    check("t6_rst_tvalid", 64'(tvalid), 64'd0);
    @(negedge aclk); aresetn = 1'b1;
    tready = 1'b1;
    cmd(32'h600, 24'd4);
    wait_done("t6", 200);
    check_stream("t6", 32'h600, 4);

    // Read-response error on beat 3 of 8
    do_reset();
    inject = 1'b1;
    cmd(32'h700, 24'd8);
    wait_done("t7", 200);
    check_stream("t7", 32'h700, 8);
`ifdef AXI4_RSTREAM_RRESP_CHECK_EN
    check("t7_err", 64'(err), 64'd1);
`else
    check("t7_err", 64'(err), 64'd0);
`endif
    repeat (3) @(negedge aclk);
    inject = 1'b0;
    cmd(32'h800, 24'd4);
    check("t7_err_cleared", 64'(err), 64'd0);
    repeat (60) @(negedge aclk);
    check("t7_busy_end", 64'(busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi4_read_stream_master.md
Name: axi4_read_stream_master

Overview:
- AXI4 read-side initiator that fetches a linear buffer from memory and emits it as an AXI4-Stream of beats (e.g. a video line or frame fetch feeding the DVI pixel path).
- Software-style command in: base address plus beat count.
- Bursts are split on MAX_BURST and 4 KB boundaries.
- Reads are paced by free space in an internal FIFO so the R channel never stalls.

Parameters:
- AXI_ID_WIDTH, 4: ARID width; ARID driven constant 0.
- AXI_ADDR_WIDTH, 32: address width.
- AXI_LEN_WIDTH, 8: ARLEN width.
- AXI_DATA_SIZE, 2: log2 bytes per beat.
- AXI_DATA_WIDTH, (8 << AXI_DATA_SIZE): data width.
- MAX_BURST, 16: maximum beats per burst, 1..(1<<AXI_LEN_WIDTH).
- FIFO_PTR_WIDTH, 6: FIFO depth = 1<<FIFO_PTR_WIDTH, which must be >= MAX_BURST.
- COUNT_WIDTH, 24: width of the beat-count command.

Ports:
- aresetn  in  1  asynchronous active-low reset
- aclk  in  1  clock
- start  in  1  one-cycle command strobe, ignored while busy
- base_addr  in  AXI_ADDR_WIDTH  start byte address; low AXI_DATA_SIZE bits forced 0
- total_beats  in  COUNT_WIDTH  beats to fetch
- busy  out  1  command in progress
- done  out  1  one-cycle pulse when the final stream beat is accepted
- err  out  1  sticky RRESP error (see Optional Feature)
- m_axi4_arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot/arqos  out  standard widths  AR channel
- m_axi4_arvalid  out  1
- m_axi4_arready  in  1
- m_axi4_rid  in  AXI_ID_WIDTH
- m_axi4_rdata  in  AXI_DATA_WIDTH
- m_axi4_rresp  in  2
- m_axi4_rlast  in  1
- m_axi4_rvalid  in  1
- m_axi4_rready  out  1
- m_axis_tdata  out  AXI_DATA_WIDTH  stream data
- m_axis_tlast  out  1  final beat of command
- m_axis_tvalid  out  1
- m_axis_tready  in  1

Behaviour:
- Reset:
  - busy, done, err, arvalid, tvalid, tlast = 0.
  - FIFO empty; counters cleared; state IDLE.
  - Reset is asynchronous and takes effect mid-burst. Outstanding R beats after reset are the fabric's concern; the bench must not rely on them.
- AR field constants: arsize = AXI_DATA_SIZE, arburst = 2'b01 (INCR), arlock = 0, arcache = 4'b0011, arprot = 3'b000, arqos = 0, arid = 0.
- FSM:
  - IDLE: on start with total_beats != 0, latch addr/remaining, set busy, go to ISSUE. On start with total_beats == 0, pulse done next cycle and stay in IDLE with busy low.
  - ISSUE:
    - len = min(MAX_BURST, remaining, (4096 - addr[11:0]) >> AXI_DATA_SIZE).
    - Assert arvalid only when fifo_count + reserved + len <= depth. reserved = beats granted but not yet written to the FIFO.
    - On arready: reserved += len, addr += len << AXI_DATA_SIZE, remaining -= len. Go to DRAIN if remaining reaches 0, else stay in ISSUE.
    - While arvalid is high, all AR fields remain stable until arready.
  - DRAIN: wait until the last stream beat is accepted, then pulse done, clear busy, return to IDLE.
- R channel:
  - rready = 1 whenever busy; space is always pre-reserved.
  - Each accepted R beat is written to the FIFO and decrements reserved.
  - A simultaneous AR grant and R beat adjusts reserved by +len-1 in one cycle.
  - rlast is not used for counting; the beat count is authoritative.
- Stream output:
  - FIFO is first-word fall-through; tvalid = !empty.
  - Once tvalid is asserted, tdata/tvalid stay stable until tready.
  - tlast = 1 on the beat whose output counter equals total_beats-1.
  - FIFO full + write cannot occur by construction. Simultaneous push/pop on an empty FIFO must not lose data: the pushed beat appears the next cycle.
- Arithmetic: address wraps at 2^AXI_ADDR_WIDTH without error; count arithmetic is unsigned.
- Maximum throughput: one beat/cycle, given an AXI slave supplying back-to-back R and continuous tready.

Optional Feature:
- AXI4_RSTREAM_RRESP_CHECK_EN:
  - Defined: err is set when any accepted R beat has rresp != 2'b00. It clears only on reset or on a new accepted start. Data is still forwarded.
  - Undefined: err is tied to 0 and rresp is ignored.

Test Plan:
- Single short command: base 0x100, total 4, MAX_BURST 16 → one AR (addr 0x100, len 3); 4 stream beats in order, tlast on beat 4; done one cycle after the 4th handshake.
- Burst splitting: base 0x0, total 40 → ARs at 0x0/0x40/0x80 with len 15/15/7; 40 beats, single tlast.
- 4 KB boundary: base 0xFF8, total 8 → AR 0xFF8 len 1, then AR 0x1000 len 5.
- Backpressure: depth 64, tready held low, total 200 → exactly 64 beats requested, arvalid low thereafter, rready never drops a beat. Releasing tready resumes AR issue; all 200 beats are delivered intact.
- Edge commands: total 0 → done pulse, no AR. start while busy → ignored. Async reset mid-DRAIN → busy/tvalid low immediately; a fresh command then completes normally.
- With AXI4_RSTREAM_RRESP_CHECK_EN: rresp = 2'b10 on beat 3 of 8 → err = 1 sticky, all 8 beats delivered; next start clears err.
